tank_pos_rx_parser: RTL and testbench

Receive-side framing stage for the two-board tank link. Consumes the byte stream from the UART receiver (one byte per `rx_done_tick`) and decodes fixed 6-byte position frames from the opponent board. It validates each frame and publishes the opponent tank's 10-bit X/Y position, holding the last good value. Its X/Y outputs feed the opponent-tank renderer and the tank generator. It also drives a link-status flag for the GUI.

---
 rtl/tank_link_pkg.sv | 20 ++
 rtl/timeout_counter.sv | 47 ++++
 rtl/tank_pos_rx_parser.sv | 135 +++++++++++++
 tb/tb_tank_pos_rx_parser.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tank_link_pkg.sv
// Shared definitions for the two-board tank link.
// Used by the receive-side parser and the transmit-side framer.
//   HEADER_BYTE : default frame start byte
//   FRAME_LEN   : bytes per position frame (header, XH, XL, YH, YL, CS)
//   rx_state_t  : receive parser FSM states, one per expected frame byte
package tank_link_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int         FRAME_LEN   = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XH   = 3'd1,
        ST_XL   = 3'd2,
        ST_YH   = 3'd3,
        ST_YL   = 3'd4,
        ST_CS   = 3'd5
    } rx_state_t;

endpackage

// File: rtl/timeout_counter.sv
// Saturating cycle counter with a registered expired flag.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (has priority over enable)
//   enable   : count up by one, stopping at LIMIT
//   expired  : registered, high while count >= LIMIT
// START_SAT selects whether reset leaves the counter saturated (expired)
// or cleared.
module timeout_counter #(
    parameter int LIMIT     = 16,
    parameter bit START_SAT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            W   = $clog2(LIMIT) + 1;
    localparam logic [W-1:0]  LIM = W'(LIMIT);

    logic [W-1:0] count;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count < LIM)) begin
            count_next = count + 1'b1;
        end
    end

    // The flag is computed from the next count so it is registered in the
    // same edge that the count reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= START_SAT ? LIM : '0;
            expired <= START_SAT;
        end else begin
            count   <= count_next;
            expired <= (count_next >= LIM);
        end
    end

endmodule

// File: rtl/tank_pos_rx_parser.sv
// Receive-side framing stage for the tank link. Decodes 6-byte frames
// (HEADER, XH, XL, YH, YL, CS) from the UART byte stream and publishes the
// opponent X/Y position, holding the last good value.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx_data      : received byte, valid when rx_done_tick=1
//   rx_done_tick : one-cycle strobe per received byte
//   x_pos, y_pos : last accepted opponent position (10 bits each)
//   pos_valid    : one-cycle pulse when x_pos/y_pos update
//   frame_err    : one-cycle pulse on a rejected or timed-out frame
//   link_up      : high while good frames keep arriving
module tank_pos_rx_parser
    import tank_link_pkg::*;
#(
    parameter logic [7:0] HEADER       = HEADER_BYTE,
    parameter int         BYTE_TIMEOUT = 130000,
    parameter int         LINK_TIMEOUT = 65000000,
    parameter logic [9:0] RESET_X      = 10'd0,
    parameter logic [9:0] RESET_Y      = 10'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       pos_valid,
    output logic       frame_err,
    output logic       link_up
);

    rx_state_t  state;
    rx_state_t  state_next;
    logic [7:0] xh_q, xl_q, yh_q, yl_q;
    logic       accept;
    logic       err_next;
    logic       byte_expired;
    logic       link_expired;

    // Inter-byte timeout: only runs mid-frame, restarts on every byte.
    timeout_counter #(
        .LIMIT     (BYTE_TIMEOUT),
        .START_SAT (1'b0)
    ) u_byte_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_done_tick || (state == ST_IDLE)),
        .enable  (state != ST_IDLE),
        .expired (byte_expired)
    );

    // Link watchdog: starts saturated so the link reads down until the
    // first good frame.
    timeout_counter #(
        .LIMIT     (LINK_TIMEOUT),
        .START_SAT (1'b1)
    ) u_link_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (1'b1),
        .expired (link_expired)
    );

    assign link_up = ~link_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        err_next   = 1'b0;
        if (rx_done_tick) begin
            // A byte arriving in the expiry cycle is processed normally.
            case (state)
                ST_IDLE: if (rx_data == HEADER) state_next = ST_XH;
                ST_XH:   state_next = ST_XL;
                ST_XL:   state_next = ST_YH;
                ST_YH:   state_next = ST_YL;
                ST_YL:   state_next = ST_CS;
                ST_CS: begin
                    state_next = ST_IDLE;
                    if ((rx_data == (xh_q ^ xl_q ^ yh_q ^ yl_q)) &&
                        (xh_q[7:2] == 6'd0) && (yh_q[7:2] == 6'd0)) begin
                        accept = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (byte_expired && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
        end
    end

    // Shadow registers capture payload bytes; outputs copy them only on
    // an accepted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            xh_q      <= 8'd0;
            xl_q      <= 8'd0;
            yh_q      <= 8'd0;
            yl_q      <= 8'd0;
            x_pos     <= RESET_X;
            y_pos     <= RESET_Y;
            pos_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_done_tick) begin
                case (state)
                    ST_XH:   xh_q <= rx_data;
                    ST_XL:   xl_q <= rx_data;
                    ST_YH:   yh_q <= rx_data;
                    ST_YL:   yl_q <= rx_data;
                    default: ;
                endcase
            end
            if (accept) begin
                x_pos <= {xh_q[1:0], xl_q};
                y_pos <= {yh_q[1:0], yl_q};
            end
            pos_valid <= accept;
            frame_err <= err_next;
        end
    end

endmodule

// File: tb/tb_tank_pos_rx_parser.sv
// Directed bench for tank_pos_rx_parser with shortened timeouts.
module tb_tank_pos_rx_parser;

    localparam int         BYTE_TO = 20;
    localparam int         LINK_TO = 300;
    localparam logic [9:0] RST_X   = 10'd11;
    localparam logic [9:0] RST_Y   = 10'd22;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       pos_valid;
    logic       frame_err;
    logic       link_up;

    int n_checks = 0;
    int n_pass   = 0;
    int pv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;

    tank_pos_rx_parser #(
        .HEADER       (8'hA5),
        .BYTE_TIMEOUT (BYTE_TO),
        .LINK_TIMEOUT (LINK_TO),
        .RESET_X      (RST_X),
        .RESET_Y      (RST_Y)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .pos_valid    (pos_valid),
        .frame_err    (frame_err),
        .link_up      (link_up)
    );

    // clock
    always #5 clk = ~clk;

    // pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (pos_valid) pv_cnt++;
        if (frame_err) fe_cnt++;
        if (pos_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_counts();
        pv_cnt = 0;
        fe_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
        send_byte(b0); send_byte(b1); send_byte(b2);
        send_byte(b3); send_byte(b4); send_byte(b5);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        check("reset_x", x_pos, RST_X);
        check("reset_y", y_pos, RST_Y);
        check("reset_link", link_up, 0);
        check("reset_pulses", {pos_valid, frame_err}, 0);

        // 1: good frame, X=300 Y=200, one-cycle latency
        clear_counts();
        send_frame(8'hA5, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'hE5);
        check("t1_pv_latency", pos_valid, 1);
        check("t1_x", x_pos, 300);
        check("t1_y", y_pos, 200);
        check("t1_link", link_up, 1);
        idle(3);
        check("t1_pv_count", pv_cnt, 1);
        check("t1_fe_count", fe_cnt, 0);

        // 2: bad checksum
        clear_counts();
        send_frame(8'hA5, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'hE4);
        check("t2_fe_latency", frame_err, 1);
        idle(3);
        check("t2_fe_count", fe_cnt, 1);
        check("t2_pv_count", pv_cnt, 0);
        check("t2_x_held", x_pos, 300);
        check("t2_y_held", y_pos, 200);

        // 3: inter-byte timeout, then a good frame
        clear_counts();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h2C);
        begin
            int waited = 0;
            while (fe_cnt == 0 && waited < BYTE_TO + 10) begin
                @(negedge clk);
                waited++;
            end
        end
        check("t3_timeout_err", fe_cnt, 1);
        clear_counts();
        send_frame(8'hA5, 8'h00, 8'h05, 8'h00, 8'h07, 8'h02);
        idle(2);
        check("t3_pv_count", pv_cnt, 1);
        check("t3_fe_count", fe_cnt, 0);
        check("t3_x", x_pos, 5);
        check("t3_y", y_pos, 7);

        // 4: garbage ignored, A5 as payload data
        clear_counts();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        idle(2);
        send_frame(8'hA5, 8'h00, 8'hA5, 8'h00, 8'h10, 8'hB5);
        idle(2);
        check("t4_fe_count", fe_cnt, 0);
        check("t4_pv_count", pv_cnt, 1);
        check("t4_x", x_pos, 165);
        check("t4_y", y_pos, 16);

        // 5: reserved XH bit set with matching checksum
        clear_counts();
        send_frame(8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04);
        idle(2);
        check("t5_fe_count", fe_cnt, 1);
        check("t5_pv_count", pv_cnt, 0);
        check("t5_x_held", x_pos, 165);

        // 6: byte arriving exactly in the expiry cycle is still accepted
        clear_counts();
        send_byte(8'hA5);
        idle(BYTE_TO);
        send_byte(8'h00); send_byte(8'h09); send_byte(8'h00);
        send_byte(8'h03); send_byte(8'h0A);
        idle(2);
        check("t6_tie_fe", fe_cnt, 0);
        check("t6_tie_pv", pv_cnt, 1);
        check("t6_tie_x", x_pos, 9);
        check("t6_tie_y", y_pos, 3);

        // 7: link watchdog
        idle(LINK_TO - 20);
        check("t7_link_still_up", link_up, 1);
        idle(30);
        check("t7_link_down", link_up, 0);

        // 8: reset mid-frame
        clear_counts();
        send_frame(8'hA5, 8'h00, 8'h05, 8'h00, 8'h07, 8'h02);
        check("t8_link_up", link_up, 1);
        send_byte(8'hA5); send_byte(8'h01);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t8_rst_x", x_pos, RST_X);
        check("t8_rst_y", y_pos, RST_Y);
        check("t8_rst_link", link_up, 0);
        idle(BYTE_TO + 10);
        check("t8_no_err", fe_cnt, 0);
        send_frame(8'hA5, 8'h03, 8'hFF, 8'h02, 8'h00, 8'hFE);
        idle(2);
        check("t8_after_x", x_pos, 1023);
        check("t8_after_y", y_pos, 512);
        check("t8_pv_count", pv_cnt, 2);

        check("pv_fe_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
